// File: rtl/led_chaser.sv
`default_nettype none
// ============================================================================
// Module   : led_chaser
// Purpose  : Free-running LED chaser. A prescaler counts WAIT_TIME clock
//            cycles per step; on each step the single lit LED moves one
//            position. The default pattern rotates left with wrap-around.
// Options  : LED_PINGPONG_EN - when defined, the lit LED bounces between the
//            two end LEDs instead of wrapping (adds a direction register).
// Ports    : clk    in   1          system clock, rising-edge active
//            rst_n  in   1          asynchronous active-low reset
//            led    out  LED_WIDTH  registered LED drive, polarity per
//                                   ACTIVE_LOW (1: lit LED driven 0)
// Revision : 1.0 - initial release
// ============================================================================
module led_chaser #(
   parameter int WAIT_TIME  = 13_500_000,
   parameter int LED_WIDTH  = 6,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [LED_WIDTH-1:0] led
);

   // A single-cycle prescale still needs a 1-bit counter to keep widths legal.
   localparam int                   CNT_W     = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
   localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(WAIT_TIME - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [LED_WIDTH-1:0] PAT_RESET = LED_WIDTH'(1);
   localparam logic [LED_WIDTH-1:0] LED_RESET = ACTIVE_LOW ? ~PAT_RESET : PAT_RESET;

   logic [CNT_W-1:0]     cnt;
   logic [LED_WIDTH-1:0] pat;
   logic [LED_WIDTH-1:0] pat_next;
   logic                 step;

   assign step = (cnt == CNT_MAX);

`ifdef LED_PINGPONG_EN
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic dir;
   logic dir_next;

   // The direction flips on the same step that lands on an end LED, so each
   // endpoint is lit for exactly one step before the pattern heads back.
   always_comb begin
      pat_next = pat;
      dir_next = dir;
      if (dir == DIR_UP) begin
         pat_next = {pat[LED_WIDTH-2:0], 1'b0};
         if (pat_next[LED_WIDTH-1]) begin
            dir_next = DIR_DOWN;
         end
      end else begin
         pat_next = {1'b0, pat[LED_WIDTH-1:1]};
         if (pat_next[0]) begin
            dir_next = DIR_UP;
         end
      end
   end
`else
   assign pat_next = {pat[LED_WIDTH-2:0], pat[LED_WIDTH-1]};
`endif

   // led is loaded from pat_next alongside pat, so the pin drive is
   // registered yet changes on the very edge the pattern advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         pat <= PAT_RESET;
         led <= LED_RESET;
`ifdef LED_PINGPONG_EN
         dir <= DIR_UP;
`endif
      end else if (step) begin
         cnt <= '0;
         pat <= pat_next;
         led <= ACTIVE_LOW ? ~pat_next : pat_next;
`ifdef LED_PINGPONG_EN
         dir <= dir_next;
`endif
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_chaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_chaser
// Purpose  : Self-checking bench for led_chaser. Two instances share clock and
//            reset: u_dut (WAIT_TIME=5, active-low) and u_fast (WAIT_TIME=1,
//            active-high). Expected LED values are derived from the number of
//            edges since reset release and queued before each edge, then
//            popped and compared after it. LED_PINGPONG_EN selects the
//            bouncing reference sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_chaser;

   localparam int W = 6;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] led;
   logic [W-1:0] led_fast;

   int errors = 0;
   int checks = 0;
   int edges  = 0;     // rising edges since the most recent reset release

   logic [W-1:0] q_dut[$];
   logic [W-1:0] q_fast[$];

   led_chaser #(.WAIT_TIME(5), .LED_WIDTH(W), .ACTIVE_LOW(1'b1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .led   (led)
   );

   led_chaser #(.WAIT_TIME(1), .LED_WIDTH(W), .ACTIVE_LOW(1'b0)) u_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .led   (led_fast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index of the lit LED after a given number of steps.
   function automatic logic [W-1:0] model_led(input int steps, input bit active_low);
      int          idx;
      logic [W-1:0] p;
`ifdef LED_PINGPONG_EN
      int m;
      m   = steps % (2 * (W - 1));
      idx = (m <= W - 1) ? m : (2 * (W - 1) - m);
`else
      idx = steps % W;
`endif
      p = '0;
      p[idx] = 1'b1;
      return active_low ? ~p : p;
   endfunction

   // Advance n edges while running; queue expectations, then check each.
   task automatic run_edges(input int n, input string tag);
      logic [W-1:0] exp_d;
      logic [W-1:0] exp_f;
      for (int i = 0; i < n; i++) begin
         edges++;
         q_dut.push_back(model_led(edges / 5, 1'b1));
         q_fast.push_back(model_led(edges, 1'b0));
         @(posedge clk);
         #1;
         exp_d = q_dut.pop_front();
         exp_f = q_fast.pop_front();
         checks++;
         if (led !== exp_d) begin
            errors++;
            $display("FAIL %s led edge=%0d got=%b exp=%b", tag, edges, led, exp_d);
         end
         checks++;
         if (led_fast !== exp_f) begin
            errors++;
            $display("FAIL %s led_fast edge=%0d got=%b exp=%b", tag, edges, led_fast, exp_f);
         end
         checks++;
         if ($countones(~led) != 1 || $countones(led_fast) != 1) begin
            errors++;
            $display("FAIL %s onehot edge=%0d got=%b/%b exp=one lit", tag, edges, led, led_fast);
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (led !== 6'b111110) begin
         errors++;
         $display("FAIL %s led got=%b exp=111110", tag, led);
      end
      checks++;
      if (led_fast !== 6'b000001) begin
         errors++;
         $display("FAIL %s led_fast got=%b exp=000001", tag, led_fast);
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      edges = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;            // asserted between edges: must act at once
      #1;
      check_reset_state("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_reset_state("reset_hold");
      end
   endtask

   task automatic test_step_timing();
      release_reset();
      run_edges(30, "step_wrap");  // covers edges 5, 10, 25-29 and wrap at 30
   endtask

   task automatic test_onehot_run();
      run_edges(600, "long_run");
   endtask

   task automatic test_midrun_reset();
      rst_n = 1'b0;
      release_reset();
      run_edges(12, "pre_reset");
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_reset_async");
      @(posedge clk);
      #1;
      check_reset_state("mid_reset_hold");
      rst_n = 1'b1;
      edges = 0;
      run_edges(12, "post_reset");
   endtask

   task automatic test_back_to_back();
      // Reset then immediately release on consecutive cycles.
      for (int r = 0; r < 2; r++) begin
         rst_n = 1'b0;
         #1;
         check_reset_state("b2b_reset");
         release_reset();
         run_edges(7, "b2b_run");
      end
   endtask

   initial begin
      rst_n = 1'b1;
      test_reset();
      test_step_timing();
      test_onehot_run();
      test_midrun_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
